// File: rtl/apple_spawner_multi.sv
//==============================================================================
// Module   : apple_spawner_multi
// Purpose  : Keeps up to NUM_APPLES apples live on an X_MAX x Y_MAX grid.
//            Positions come from a free-running 16-bit Galois LFSR using
//            rejection sampling. Every BONUS_EVERY-th spawn is a bonus apple
//            that expires after BONUS_LIFE snake steps. When the head eats an
//            apple, the body-growth controller gets a one-cycle pulse with the
//            number of segments to add.
// Ports    : Clk_50mhz    - system clock
//            Rst_n        - asynchronous active-low reset
//            Step_en      - one-cycle pulse, snake head has moved
//            Head_x/y     - snake head coordinates
//            Apple_x/y    - packed slot coordinates (slot i at [i*W +: W])
//            Apple_type   - 1 = bonus, 0 = normal
//            Apple_valid  - slot holds a live apple
//            Body_add_sig - one-cycle growth pulse
//            Add_len      - segments to add (1 normal, 3 bonus), else 0
//            Eaten_onehot - eaten slot, valid with Body_add_sig, else 0
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module apple_spawner_multi #(
    parameter int          NUM_APPLES  = 3,
    parameter int          X_W         = 6,
    parameter int          Y_W         = 5,
    parameter int          X_MAX       = 39,
    parameter int          Y_MAX       = 29,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          BONUS_EVERY = 4,
    parameter int          BONUS_LIFE  = 64
) (
    input  logic                      Clk_50mhz,
    input  logic                      Rst_n,
    input  logic                      Step_en,
    input  logic [X_W-1:0]            Head_x,
    input  logic [Y_W-1:0]            Head_y,
    output logic [NUM_APPLES*X_W-1:0] Apple_x,
    output logic [NUM_APPLES*Y_W-1:0] Apple_y,
    output logic [NUM_APPLES-1:0]     Apple_type,
    output logic [NUM_APPLES-1:0]     Apple_valid,
    output logic                      Body_add_sig,
    output logic [1:0]                Add_len,
    output logic [NUM_APPLES-1:0]     Eaten_onehot
);

    localparam int                 c_cnt_w    = $clog2(BONUS_EVERY);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BONUS_EVERY - 1);
    localparam logic [X_W-1:0]     c_x_max    = X_W'(X_MAX);
    localparam logic [Y_W-1:0]     c_y_max    = Y_W'(Y_MAX);
    localparam logic [7:0]         c_life     = 8'(BONUS_LIFE);
    // Right-shift Galois taps for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0]        c_taps     = 16'hB400;

    // Registered state
    logic [15:0]           r_lfsr;
    logic [c_cnt_w-1:0]    r_spawn_cnt;
    logic [X_W-1:0]        r_x    [NUM_APPLES];
    logic [Y_W-1:0]        r_y    [NUM_APPLES];
    logic [7:0]            r_life [NUM_APPLES];
    logic [NUM_APPLES-1:0] r_valid;
    logic [NUM_APPLES-1:0] r_type;
    logic                  r_body_add;
    logic [1:0]            r_add_len;
    logic [NUM_APPLES-1:0] r_eaten;

    // Combinational decode
    logic [X_W-1:0]        w_cx;
    logic [Y_W-1:0]        w_cy;
    logic [NUM_APPLES-1:0] w_eat;
    logic [NUM_APPLES-1:0] w_expire;
    logic [NUM_APPLES-1:0] w_free_sel;
    logic                  w_eat_any;
    logic                  w_eat_bonus;
    logic                  w_expire_any;
    logic                  w_clash;
    logic                  w_in_range;
    logic                  w_spawn;
    logic                  w_spawn_bonus;

    assign w_cx = r_lfsr[X_W-1:0];
    assign w_cy = r_lfsr[X_W+Y_W-1:X_W];

    always_comb begin
        w_eat    = '0;
        w_expire = '0;
        w_clash  = (w_cx == Head_x) && (w_cy == Head_y);
        for (int i = 0; i < NUM_APPLES; i++) begin
            w_eat[i] = Step_en && r_valid[i] &&
                       (r_x[i] == Head_x) && (r_y[i] == Head_y);
            // Eating the slot takes priority over its expiry.
            w_expire[i] = Step_en && r_valid[i] && r_type[i] &&
                          !w_eat[i] && (r_life[i] == 8'd1);
            if (r_valid[i] && (r_x[i] == w_cx) && (r_y[i] == w_cy))
                w_clash = 1'b1;
        end
    end

    assign w_eat_any     = |w_eat;
    assign w_eat_bonus   = |(w_eat & r_type);
    assign w_expire_any  = |w_expire;
    assign w_in_range    = (w_cx <= c_x_max) && (w_cy <= c_y_max);

    // Lowest clear bit of r_valid: ~v & (v + 1) isolates it as a one-hot.
    assign w_free_sel    = ~r_valid & (r_valid + NUM_APPLES'(1));

    // Any eat or expiry this cycle blocks the spawn; the freed slot is only
    // offered to the spawner on the following cycle.
    assign w_spawn       = w_in_range && !w_clash && !w_eat_any &&
                           !w_expire_any && (w_free_sel != '0);
    assign w_spawn_bonus = (r_spawn_cnt == c_cnt_last);

    // LFSR, spawn counter and growth pulse
    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_lfsr      <= LFSR_SEED;
            r_spawn_cnt <= '0;
            r_body_add  <= 1'b0;
            r_add_len   <= 2'd0;
            r_eaten     <= '0;
        end else begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? c_taps : 16'h0000);
            if (w_spawn)
                r_spawn_cnt <= w_spawn_bonus ? '0 : r_spawn_cnt + 1'b1;
            r_body_add <= w_eat_any;
            r_add_len  <= w_eat_any ? (w_eat_bonus ? 2'd3 : 2'd1) : 2'd0;
            r_eaten    <= w_eat;
        end
    end

    // Apple slots
    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_valid <= '0;
            r_type  <= '0;
            for (int i = 0; i < NUM_APPLES; i++) begin
                r_x[i]    <= '0;
                r_y[i]    <= '0;
                r_life[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_APPLES; i++) begin
                if (w_eat[i] || w_expire[i]) begin
                    r_valid[i] <= 1'b0;
                    r_life[i]  <= 8'd0;
                end else if (w_spawn && w_free_sel[i]) begin
                    r_valid[i] <= 1'b1;
                    r_x[i]     <= w_cx;
                    r_y[i]     <= w_cy;
                    r_type[i]  <= w_spawn_bonus;
                    r_life[i]  <= w_spawn_bonus ? c_life : 8'd0;
                end else if (Step_en && r_valid[i] && r_type[i] &&
                             (r_life[i] != 8'd0)) begin
                    r_life[i] <= r_life[i] - 8'd1;
                end
            end
        end
    end

    // Output packing
    generate
        for (genvar g = 0; g < NUM_APPLES; g++) begin : g_pack
            assign Apple_x[g*X_W +: X_W] = r_x[g];
            assign Apple_y[g*Y_W +: Y_W] = r_y[g];
        end
    endgenerate

    assign Apple_type   = r_type;
    assign Apple_valid  = r_valid;
    assign Body_add_sig = r_body_add;
    assign Add_len      = r_add_len;
    assign Eaten_onehot = r_eaten;

endmodule

`default_nettype wire

// File: tb/tb_apple_spawner_multi.sv
//==============================================================================
// Module   : tb_apple_spawner_multi
// Purpose  : Directed self-checking bench for apple_spawner_multi with the
//            default parameters (3 slots, 40x30 grid, bonus every 4th spawn,
//            bonus life 64 steps). Expected spawn positions after reset come
//            from a small LFSR rejection-sampling reference.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_apple_spawner_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        step_en;
    logic [5:0]  head_x;
    logic [4:0]  head_y;
    logic [17:0] apple_x;
    logic [14:0] apple_y;
    logic [2:0]  apple_type;
    logic [2:0]  apple_valid;
    logic        body_add_sig;
    logic [1:0]  add_len;
    logic [2:0]  eaten_onehot;

    int n_vec = 0;
    int n_err = 0;
    int pulse_cnt = 0;
    int dbl_cnt = 0;
    logic prev_pulse = 1'b0;

    logic [5:0] mx [3];
    logic [4:0] my [3];

    always #10 clk = ~clk;

    apple_spawner_multi dut (
        .Clk_50mhz    (clk),
        .Rst_n        (rst_n),
        .Step_en      (step_en),
        .Head_x       (head_x),
        .Head_y       (head_y),
        .Apple_x      (apple_x),
        .Apple_y      (apple_y),
        .Apple_type   (apple_type),
        .Apple_valid  (apple_valid),
        .Body_add_sig (body_add_sig),
        .Add_len      (add_len),
        .Eaten_onehot (eaten_onehot)
    );

    // Growth-pulse monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (body_add_sig === 1'b1) begin
            pulse_cnt++;
            if (prev_pulse) dbl_cnt++;
        end
        prev_pulse = (body_add_sig === 1'b1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] get_x(input int i);
        return apple_x[i*6 +: 6];
    endfunction

    function automatic logic [4:0] get_y(input int i);
        return apple_y[i*5 +: 5];
    endfunction

    // First three accepted candidates from the seed with a static head and
    // no step activity; these land in slots 0, 1, 2 in order.
    task automatic model_fill(input logic [5:0] hx, input logic [4:0] hy);
        logic [15:0] l;
        logic [5:0]  cx;
        logic [4:0]  cy;
        logic        ok;
        int          n;
        l = 16'hACE1;
        n = 0;
        for (int s = 0; s < 2000 && n < 3; s++) begin
            cx = l[5:0];
            cy = l[10:6];
            ok = (cx <= 6'd39) && (cy <= 5'd29) && !(cx == hx && cy == hy);
            for (int j = 0; j < n; j++)
                if (mx[j] == cx && my[j] == cy) ok = 1'b0;
            if (ok) begin
                mx[n] = cx;
                my[n] = cy;
                n++;
            end
            l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
        end
    endtask

    // All valid apples in range, pairwise distinct and off the head
    task automatic chk_board(input string tag);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (apple_valid[i]) begin
                if (get_x(i) > 6'd39 || get_y(i) > 5'd29) ok = 1'b0;
                if (get_x(i) == head_x && get_y(i) == head_y) ok = 1'b0;
                for (int j = i + 1; j < 3; j++)
                    if (apple_valid[j] && get_x(i) == get_x(j) && get_y(i) == get_y(j))
                        ok = 1'b0;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_slot(input int idx, input string tag);
        for (int k = 0; k < 64 && apple_valid[idx] !== 1'b1; k++) tick();
        chk(tag, 32'(apple_valid[idx]), 32'd1);
    endtask

    task automatic wait_full(input string tag);
        for (int k = 0; k < 64 && apple_valid !== 3'b111; k++) tick();
        chk(tag, 32'(apple_valid), 32'h7);
    endtask

    // Hold reset, check cleared outputs, release with the given head and
    // compare the first fill against the reference.
    task automatic reset_and_fill(input logic [5:0] hx, input logic [4:0] hy, input string tag);
        rst_n   = 1'b0;
        step_en = 1'b0;
        head_x  = hx;
        head_y  = hy;
        repeat (3) tick();
        chk({tag, "_rst_valid"}, 32'(apple_valid), 32'd0);
        chk({tag, "_rst_body"}, 32'(body_add_sig), 32'd0);
        chk({tag, "_rst_x"}, 32'(apple_x), 32'd0);
        rst_n = 1'b1;
        model_fill(hx, hy);
        wait_full({tag, "_fill"});
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_x%0d", tag, i), 32'(get_x(i)), 32'(mx[i]));
            chk($sformatf("%s_y%0d", tag, i), 32'(get_y(i)), 32'(my[i]));
        end
        chk({tag, "_types"}, 32'(apple_type), 32'd0);
        chk_board({tag, "_board"});
    endtask

    task automatic eat_slot(input int idx, input logic [1:0] exp_len, input logic exp_type);
        logic [5:0] ox;
        logic [4:0] oy;
        ox      = get_x(idx);
        oy      = get_y(idx);
        head_x  = ox;
        head_y  = oy;
        step_en = 1'b1;
        tick();
        step_en = 1'b0;
        chk("eat_pulse", 32'(body_add_sig), 32'd1);
        chk("eat_len", 32'(add_len), 32'(exp_len));
        chk("eat_onehot", 32'(eaten_onehot), 32'(1 << idx));
        chk("eat_clear", 32'(apple_valid[idx]), 32'd0);
        tick();
        chk("pulse_width", 32'(body_add_sig), 32'd0);
        chk("len_idle", 32'(add_len), 32'd0);
        wait_slot(idx, "respawn");
        chk("respawn_type", 32'(apple_type[idx]), 32'(exp_type));
        chk("respawn_moved", 32'((get_x(idx) != ox) || (get_y(idx) != oy)), 32'd1);
        chk_board("respawn_board");
        head_x = 6'd63;
        head_y = 5'd31;
    endtask

    initial begin
        int base;
        logic [5:0] px;
        logic [4:0] py;

        // Fill after reset; spawn counter ends at 3
        reset_and_fill(6'd28, 5'd13, "init");

        // Normal eat -> respawn is the bonus; then eat that bonus
        eat_slot(0, 2'd1, 1'b1);
        eat_slot(0, 2'd3, 1'b0);

        // Cycle the spawn counter so slot 1 becomes the next bonus
        eat_slot(1, 2'd1, 1'b0);
        eat_slot(1, 2'd1, 1'b0);
        eat_slot(1, 2'd1, 1'b1);

        // Bonus expiry after exactly 64 steps, no growth pulse
        head_x = 6'd63;
        head_y = 5'd31;
        base   = pulse_cnt;
        for (int p = 1; p <= 64; p++) begin
            step_en = 1'b1;
            tick();
            step_en = 1'b0;
            if (p == 63) chk("expire_alive63", 32'(apple_valid[1]), 32'd1);
            if (p == 64) begin
                chk("expire_gone64", 32'(apple_valid[1]), 32'd0);
                chk("expire_no_pulse_now", 32'(body_add_sig), 32'd0);
            end
            tick();
        end
        chk("expire_no_pulse", 32'(pulse_cnt - base), 32'd0);
        wait_slot(1, "expire_refill");
        chk("expire_refill_type", 32'(apple_type[1]), 32'd0);

        // Head parked on an apple without Step_en
        px     = get_x(0);
        py     = get_y(0);
        head_x = px;
        head_y = py;
        base   = pulse_cnt;
        repeat (100) tick();
        chk("park_no_pulse", 32'(pulse_cnt - base), 32'd0);
        chk("park_valid", 32'(apple_valid[0]), 32'd1);
        chk("park_pos", 32'({get_x(0), get_y(0)}), 32'({px, py}));

        // Reset landing on a live growth pulse
        head_x  = get_x(2);
        head_y  = get_y(2);
        step_en = 1'b1;
        tick();
        step_en = 1'b0;
        chk("mid_pulse", 32'(body_add_sig), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_body", 32'(body_add_sig), 32'd0);
        chk("mid_rst_len", 32'(add_len), 32'd0);
        chk("mid_rst_onehot", 32'(eaten_onehot), 32'd0);
        chk("mid_rst_valid", 32'(apple_valid), 32'd0);
        chk("mid_rst_y", 32'(apple_y), 32'd0);
        reset_and_fill(6'd28, 5'd13, "rerun");

        // Head sits on the very first candidate (33,19): it must be skipped
        reset_and_fill(6'd33, 5'd19, "headrej");
        chk("headrej_slot0", 32'((get_x(0) == 6'd33) && (get_y(0) == 5'd19)), 32'd0);

        chk("double_pulse", 32'(dbl_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
